sequence_bit_transmitter: RTL

- Generates the serial bit stream that the team's overlapping sequence detector consumes; it is the transmit end of that single-bit serial interface.
- Accepts a command (bit pattern, pattern length, repeat count) through a valid/ready handshake.
- Emits the pattern MSB-first, one bit per clock, with no gap between repetitions.
- Used as a stimulus source in front of the detector and as a standalone serializer.

---
 rtl/sequence_pkg.sv | 20 ++
 rtl/seq_tx_counter.sv | 42 ++++
 rtl/sequence_bit_transmitter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sequence_pkg.sv
// Shared definitions for the sequence bit transmitter and its companion detector.
package sequence_pkg;

    // FSM encoding; the spare code 2'b11 is treated as IDLE by the transmitter.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Default geometry of the command interface.
    localparam int WIDTH_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int REP_W_DEF = 4;

    // Patterns the downstream overlapping detector looks for.
    localparam logic [2:0] PAT_101 = 3'b101;
    localparam logic [2:0] PAT_110 = 3'b110;

endpackage

// File: rtl/seq_tx_counter.sv
// Loadable down-counter with a terminal (zero) flag. It saturates at zero
// instead of wrapping, so a stray decrement can never restart a sequence.
module seq_tx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: load has priority over decrement; hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (dec_en && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == {W{1'b0}});

endmodule

// File: rtl/sequence_bit_transmitter.sv
// Serializes a captured bit pattern MSB-first, repeating it back-to-back
// repeat_cnt times, then pulses done for one cycle.
module sequence_bit_transmitter
    import sequence_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_e            state_d, state_q;
    logic [WIDTH-1:0]  pattern_d, pattern_q;
    logic [LEN_W-1:0]  len_d, len_q;
    logic              out_d, out_q;
    logic              out_valid_d, out_valid_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;

    logic [LEN_W-1:0]  len_clamp_s;
    logic              bit_load_s, bit_dec_s, bit_zero_s;
    logic [LEN_W-1:0]  bit_load_val_s, bit_cnt_s;
    logic              rep_load_s, rep_dec_s, rep_zero_s;
    logic [REP_W-1:0]  rep_load_val_s, rep_cnt_s;
    logic              unused_s;

    // Select one pattern bit by index via a shift, so the index width may
    // exceed the log2 of the pattern width without a partial-index slice.
    function automatic logic bit_at(input logic [WIDTH-1:0] p,
                                    input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted = p >> idx;
        return shifted[0];
    endfunction

    // Only the repeat counter's terminal flag steers the FSM.
    assign unused_s = ^rep_cnt_s;

    // Clamp the requested length to the pattern width.
    always_comb begin
        if (length > LEN_W'(WIDTH)) begin
            len_clamp_s = LEN_W'(WIDTH);
        end else begin
            len_clamp_s = length;
        end
    end

    // Bit index within the current repetition.
    seq_tx_counter #(.W(LEN_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (bit_load_s),
        .load_val (bit_load_val_s),
        .dec_en   (bit_dec_s),
        .count    (bit_cnt_s),
        .zero     (bit_zero_s)
    );

    // Repetitions still to send after the current one.
    seq_tx_counter #(.W(REP_W)) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (rep_load_s),
        .load_val (rep_load_val_s),
        .dec_en   (rep_dec_s),
        .count    (rep_cnt_s),
        .zero     (rep_zero_s)
    );

    // Next-state, counter control and next output values. Outputs are
    // derived from the next state so that they are registered together.
    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        len_d          = len_q;
        out_d          = 1'b0;
        bit_load_s     = 1'b0;
        bit_load_val_s = {LEN_W{1'b0}};
        bit_dec_s      = 1'b0;
        rep_load_s     = 1'b0;
        rep_load_val_s = {REP_W{1'b0}};
        rep_dec_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    pattern_d = pattern;
                    len_d     = len_clamp_s;
                    if ((len_clamp_s == {LEN_W{1'b0}}) || (repeat_cnt == {REP_W{1'b0}})) begin
                        state_d = DONE;
                    end else begin
                        state_d        = SHIFT;
                        bit_load_s     = 1'b1;
                        bit_load_val_s = len_clamp_s - {{(LEN_W-1){1'b0}}, 1'b1};
                        rep_load_s     = 1'b1;
                        rep_load_val_s = repeat_cnt - {{(REP_W-1){1'b0}}, 1'b1};
                        out_d          = bit_at(pattern, len_clamp_s - {{(LEN_W-1){1'b0}}, 1'b1});
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_zero_s) begin
                    if (rep_zero_s) begin
                        state_d = DONE;
                    end else begin
                        state_d        = SHIFT;
                        bit_load_s     = 1'b1;
                        bit_load_val_s = len_q - {{(LEN_W-1){1'b0}}, 1'b1};
                        rep_dec_s      = 1'b1;
                        out_d          = bit_at(pattern_q, len_q - {{(LEN_W-1){1'b0}}, 1'b1});
                    end
                end else begin
                    state_d   = SHIFT;
                    bit_dec_s = 1'b1;
                    out_d     = bit_at(pattern_q, bit_cnt_s - {{(LEN_W-1){1'b0}}, 1'b1});
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pattern_q   <= {WIDTH{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Ready decoded from state alone; the unused code counts as IDLE.
    assign start_ready = (state_q != SHIFT) && (state_q != DONE);
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
